cross_term_mac_seq: RTL and testbench

//  Sequential, parametrised cross-term unit for the FP mantissa multiplier.

---
 rtl/cross_term_pkg.sv | 16 +
 rtl/shift_add_step.sv | 14 +
 rtl/cross_term_mac_seq.sv | 152 +++++++++++++++
 tb/tb_cross_term_mac_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cross_term_pkg.sv
// cross_term_pkg: shared states, widths and saturation helpers for the cross-term MAC
package cross_term_pkg;
    typedef enum logic [2:0] {IDLE, MUL_AD, MUL_CB, SUM, DONE} state_t;
    function automatic int sum_w(input int hi_w, input int lo_w);
        return hi_w + lo_w + 2;
    endfunction
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction
    function automatic logic sat_hit(input longint s, input int w);
        return s > sat_max(w) || s < -sat_max(w) - 64'sd1;
    endfunction
    function automatic longint sat_clamp(input longint s, input int w);
        return s > sat_max(w) ? sat_max(w) : s < -sat_max(w) - 64'sd1 ? -sat_max(w) - 64'sd1 : s;
    endfunction
endpackage

// File: rtl/shift_add_step.sv
// shift_add_step: one radix-2 shift-add step, acc + (bit ? mcand << shift : 0)
module shift_add_step #(
    parameter int MW  = 7,
    parameter int AW  = 15,
    parameter int SHW = 3
) (
    input  logic [AW-1:0]  acc_i,
    input  logic [MW-1:0]  mcand_i,
    input  logic           bit_i,
    input  logic [SHW-1:0] shift_i,
    output logic [AW-1:0]  acc_o
);
    assign acc_o = acc_i + (bit_i ? AW'(mcand_i) << shift_i : '0);
endmodule

// File: rtl/cross_term_mac_seq.sv
// cross_term_mac_seq: sequential (+/-)hi_a*lo_d + (+/-)hi_c*lo_b on one shared shift-add step
// CROSS_TERM_SAT_EN selects saturating output (default: wrap, sat tied low)
module cross_term_mac_seq
    import cross_term_pkg::*;
#(
    parameter int HI_W  = 7,
    parameter int LO_W  = 8,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [HI_W-1:0]  hi_a,
    input  logic             sign_a,
    input  logic [HI_W-1:0]  hi_c,
    input  logic             sign_c,
    input  logic [LO_W-1:0]  lo_b,
    input  logic [LO_W-1:0]  lo_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             sat
);
    localparam int SW = sum_w(HI_W, LO_W);
    localparam int PW = HI_W + LO_W;
    localparam int CW = LO_W > 1 ? $clog2(LO_W) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [HI_W-1:0]  hi_a_q, hi_a_d, hi_c_q, hi_c_d;
    logic             sign_a_q, sign_a_d, sign_c_q, sign_c_d;
    logic [LO_W-1:0]  lo_b_q, lo_b_d, lo_d_q, lo_d_d;
    logic [PW-1:0]    prod_ad_q, prod_ad_d, prod_cb_q, prod_cb_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             sat_q, sat_d;
    logic [PW-1:0]    step_acc, step_res;
    logic [HI_W-1:0]  step_mcand;
    logic             step_bit, last;
    logic [SW-1:0]    mag_ad, mag_cb, term_ad, term_cb, sum_v;
    longint           sum_l;

    // lo operands shift right each cycle so the current multiplier bit is always bit 0
    assign step_acc   = state_q == MUL_AD ? prod_ad_q : prod_cb_q;
    assign step_mcand = state_q == MUL_AD ? hi_a_q : hi_c_q;
    assign step_bit   = state_q == MUL_AD ? lo_d_q[0] : lo_b_q[0];
    assign last       = cnt_q == CW'(LO_W - 1);

    shift_add_step #(.MW(HI_W), .AW(PW), .SHW(CW)) u_step (
        .acc_i   (step_acc),
        .mcand_i (step_mcand),
        .bit_i   (step_bit),
        .shift_i (cnt_q),
        .acc_o   (step_res)
    );

    // negating a zero magnitude yields zero, so no negative zero can appear
    assign mag_ad  = SW'(prod_ad_q);
    assign mag_cb  = SW'(prod_cb_q);
    assign term_ad = sign_a_q ? -mag_ad : mag_ad;
    assign term_cb = sign_c_q ? -mag_cb : mag_cb;
    assign sum_v   = term_ad + term_cb;
    assign sum_l   = longint'($signed(sum_v));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_a_d    = hi_a_q;
        hi_c_d    = hi_c_q;
        sign_a_d  = sign_a_q;
        sign_c_d  = sign_c_q;
        lo_b_d    = lo_b_q;
        lo_d_d    = lo_d_q;
        prod_ad_d = prod_ad_q;
        prod_cb_d = prod_cb_q;
        out_d     = out_q;
        sat_d     = sat_q;
        case (state_q)
            IDLE: if (in_valid) begin
                hi_a_d    = hi_a;
                hi_c_d    = hi_c;
                sign_a_d  = sign_a;
                sign_c_d  = sign_c;
                lo_b_d    = lo_b;
                lo_d_d    = lo_d;
                prod_ad_d = '0;
                prod_cb_d = '0;
                cnt_d     = '0;
                state_d   = MUL_AD;
            end
            MUL_AD: begin
                prod_ad_d = step_res;
                lo_d_d    = lo_d_q >> 1;
                cnt_d     = last ? '0 : cnt_q + 1'b1;
                state_d   = last ? MUL_CB : MUL_AD;
            end
            MUL_CB: begin
                prod_cb_d = step_res;
                lo_b_d    = lo_b_q >> 1;
                cnt_d     = last ? '0 : cnt_q + 1'b1;
                state_d   = last ? SUM : MUL_CB;
            end
            SUM: begin
`ifdef CROSS_TERM_SAT_EN
                out_d = OUT_W'(sat_clamp(sum_l, OUT_W));
                sat_d = sat_hit(sum_l, OUT_W);
`else
                out_d = OUT_W'(sum_l);
                sat_d = 1'b0;
`endif
                state_d = DONE;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_a_q    <= '0;
            hi_c_q    <= '0;
            sign_a_q  <= 1'b0;
            sign_c_q  <= 1'b0;
            lo_b_q    <= '0;
            lo_d_q    <= '0;
            prod_ad_q <= '0;
            prod_cb_q <= '0;
            out_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_a_q    <= hi_a_d;
            hi_c_q    <= hi_c_d;
            sign_a_q  <= sign_a_d;
            sign_c_q  <= sign_c_d;
            lo_b_q    <= lo_b_d;
            lo_d_q    <= lo_d_d;
            prod_ad_q <= prod_ad_d;
            prod_cb_q <= prod_cb_d;
            out_q     <= out_d;
            sat_q     <= sat_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out       = out_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_cross_term_mac_seq.sv
// tb_cross_term_mac_seq: vector table, corner sequences and random ops vs. arithmetic model
module tb_cross_term_mac_seq;
    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready, sign_a, sign_c;
    logic [6:0] hi_a, hi_c;
    logic [7:0] lo_b, lo_d;
    logic ir32, ov32, s32, ir16, ov16, s16;
    logic [31:0] o32;
    logic [15:0] o16;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  a;
        logic        sa;
        logic [6:0]  c;
        logic        sc;
        logic [7:0]  b;
        logic [7:0]  d;
        logic [31:0] e32;
        logic [15:0] e16;
        logic        es16;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    cross_term_mac_seq d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .hi_a(hi_a), .sign_a(sign_a), .hi_c(hi_c), .sign_c(sign_c),
        .lo_b(lo_b), .lo_d(lo_d), .out_valid(ov32), .out_ready(out_ready),
        .out(o32), .sat(s32)
    );

    cross_term_mac_seq #(.OUT_W(16)) d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .hi_a(hi_a), .sign_a(sign_a), .hi_c(hi_c), .sign_c(sign_c),
        .lo_b(lo_b), .lo_d(lo_d), .out_valid(ov16), .out_ready(out_ready),
        .out(o16), .sat(s16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint model(input longint a, sa, c, sc, b, d);
        return (sa != 0 ? -(a * d) : a * d) + (sc != 0 ? -(c * b) : c * b);
    endfunction

    function automatic logic [16:0] model16(input longint s);
`ifdef CROSS_TERM_SAT_EN
        if (s > 32767) return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, s[15:0]};
    endfunction

    task automatic scramble();
        hi_a = 7'($urandom); hi_c = 7'($urandom);
        lo_b = 8'($urandom); lo_d = 8'($urandom);
        sign_a = 1'($urandom); sign_c = 1'($urandom);
    endtask

    task automatic run_op(input logic [6:0] a, input logic sa, input logic [6:0] c, input logic sc,
                          input logic [7:0] b, input logic [7:0] d, input logic [31:0] e32,
                          input logic [15:0] e16, input logic es16, input int hold);
        int lat;
        @(negedge clk);
        chk("in_ready_idle", 64'(ir32), 64'd1);
        hi_a = a; sign_a = sa; hi_c = c; sign_c = sc; lo_b = b; lo_d = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        lat = 0;
        while (!ov32 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd17);
        chk("in_ready_busy", 64'(ir32), 64'd0);
        chk("out32", 64'(o32), 64'(e32));
        chk("sat32", 64'(s32), 64'd0);
        chk("valid16", 64'(ov16), 64'd1);
        chk("out16", 64'(o16), 64'(e16));
        chk("sat16", 64'(s16), 64'(es16));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = (i == 1);
            if (i == 1) scramble();
            chk("bp_out", 64'(o32), 64'(e32));
            chk("bp_valid", 64'(ov32), 64'd1);
            chk("bp_in_ready", 64'(ir32), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_fall", 64'(ov32), 64'd0);
        chk("in_ready_back", 64'(ir32), 64'd1);
        chk("out_held", 64'(o32), 64'(e32));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        longint s;
        logic [16:0] r16;
        logic [6:0] a, c;
        logic [7:0] b, d;
        logic sa, sc;
        tbl[0] = '{7'd5, 1'b0, 7'd2, 1'b0, 8'd4, 8'd3, 32'h00000017, 16'h0017, 1'b0};
        tbl[1] = '{7'd5, 1'b1, 7'd2, 1'b0, 8'd4, 8'd3, 32'hFFFFFFF9, 16'hFFF9, 1'b0};
`ifdef CROSS_TERM_SAT_EN
        tbl[2] = '{7'd127, 1'b0, 7'd127, 1'b0, 8'd255, 8'd255, 32'h0000FD02, 16'h7FFF, 1'b1};
        tbl[3] = '{7'd127, 1'b1, 7'd127, 1'b1, 8'd255, 8'd255, 32'hFFFF02FE, 16'h8000, 1'b1};
`else
        tbl[2] = '{7'd127, 1'b0, 7'd127, 1'b0, 8'd255, 8'd255, 32'h0000FD02, 16'hFD02, 1'b0};
        tbl[3] = '{7'd127, 1'b1, 7'd127, 1'b1, 8'd255, 8'd255, 32'hFFFF02FE, 16'h02FE, 1'b0};
`endif
        tbl[4] = '{7'd0, 1'b1, 7'd0, 1'b1, 8'd200, 8'd100, 32'h00000000, 16'h0000, 1'b0};
        tbl[5] = '{7'd127, 1'b1, 7'd0, 1'b0, 8'd9, 8'd255, 32'hFFFF817F, 16'h817F, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        hi_a = '0; hi_c = '0; lo_b = '0; lo_d = '0; sign_a = 1'b0; sign_c = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(ir32), 64'd1);
        chk("rst_out_valid", 64'(ov32), 64'd0);
        chk("rst_out", 64'(o32), 64'd0);
        chk("rst_sat", 64'(s32), 64'd0);
        chk("rst_out16", 64'({s16, o16}), 64'd0);
        rst_n = 1'b1;

        foreach (tbl[i])
            run_op(tbl[i].a, tbl[i].sa, tbl[i].c, tbl[i].sc, tbl[i].b, tbl[i].d,
                   tbl[i].e32, tbl[i].e16, tbl[i].es16, 0);

        run_op(7'd5, 1'b0, 7'd2, 1'b0, 8'd4, 8'd3, 32'h17, 16'h17, 1'b0, 5);

        @(negedge clk);
        hi_a = 7'd99; lo_d = 8'd77; hi_c = 7'd3; lo_b = 8'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(ov32), 64'd0);
        chk("midrst_in_ready", 64'(ir32), 64'd1);
        chk("midrst_out", 64'(o32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_output", 64'(ov32), 64'd0);
        run_op(7'd1, 1'b0, 7'd0, 1'b0, 8'd0, 8'd1, 32'd1, 16'd1, 1'b0, 0);

        for (int n = 0; n < 30; n++) begin
            a = 7'($urandom); c = 7'($urandom); b = 8'($urandom); d = 8'($urandom);
            sa = 1'($urandom); sc = 1'($urandom);
            if (n % 7 == 0) a = '0;
            if (n % 5 == 0) b = '0;
            s = model(longint'(a), longint'(sa), longint'(c), longint'(sc), longint'(b), longint'(d));
            r16 = model16(s);
            run_op(a, sa, c, sc, b, d, s[31:0], r16[15:0], r16[16], int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
